// File: rtl/loop_step_counter_if.sv
// ---------------------------------------------------------------------------
// loop_step_counter_if
// Control/status bundle for the loop/step counter.
//   master : sequencer side  - drives start/stop/step_tick/loops/length
//                              (and pause when LOOP_STEP_COUNTER_PAUSE_EN)
//   slave  : counter side    - drives play/step_idx/loop_idx/loop_wrap/done
// Optional macro: LOOP_STEP_COUNTER_PAUSE_EN adds the pause signal.
// ---------------------------------------------------------------------------
interface loop_step_counter_if #(
    parameter int STEP_W = 4,
    parameter int LOOP_W = 8
);
    logic              start;
    logic              stop;
    logic              step_tick;
    logic [LOOP_W-1:0] loops;
    logic [STEP_W-1:0] length;
`ifdef LOOP_STEP_COUNTER_PAUSE_EN
    logic              pause;
`endif
    logic              play;
    logic [STEP_W-1:0] step_idx;
    logic [LOOP_W-1:0] loop_idx;
    logic              loop_wrap;
    logic              done;

    modport master (
        output start, stop, step_tick, loops, length,
`ifdef LOOP_STEP_COUNTER_PAUSE_EN
        output pause,
`endif
        input  play, step_idx, loop_idx, loop_wrap, done
    );

    modport slave (
        input  start, stop, step_tick, loops, length,
`ifdef LOOP_STEP_COUNTER_PAUSE_EN
        input  pause,
`endif
        output play, step_idx, loop_idx, loop_wrap, done
    );
endinterface

// File: rtl/loop_step_counter.sv
// ---------------------------------------------------------------------------
// loop_step_counter
// Tick-enabled step/loop counter for the step sequencer. Start latches the
// loop count and loop length and begins a run; each step tick advances the
// step index, wrapping into the next loop, and a finite run ends itself on
// the tick that completes the last loop.
//   clk_i  : system clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : slave side of loop_step_counter_if (controls in, status out)
// Optional macro: LOOP_STEP_COUNTER_PAUSE_EN adds bus.pause, which freezes
// the run and drops play while held.
// All outputs are registered.
// ---------------------------------------------------------------------------
module loop_step_counter #(
    parameter int STEP_W = 4,
    parameter int LOOP_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    loop_step_counter_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [LOOP_W-1:0] loop_q, loop_d;
    logic [STEP_W-1:0] len_l_q, len_l_d;
    logic [LOOP_W-1:0] loops_l_q, loops_l_d;
    logic              play_q, play_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;
    logic              pause;
    logic [STEP_W-1:0] last_step;
    logic [LOOP_W-1:0] last_loop;

`ifdef LOOP_STEP_COUNTER_PAUSE_EN
    assign pause = bus.pause;
`else
    assign pause = 1'b0;
`endif

    // Length 0 means 2**STEP_W steps; the modular subtraction makes the last
    // index all-ones in that case with no special handling.
    assign last_step = len_l_q - 1'b1;
    assign last_loop = loops_l_q - 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            step_q    <= '0;
            loop_q    <= '0;
            len_l_q   <= '0;
            loops_l_q <= '0;
            play_q    <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            loop_q    <= loop_d;
            len_l_q   <= len_l_d;
            loops_l_q <= loops_l_d;
            play_q    <= play_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        loop_d    = loop_q;
        len_l_d   = len_l_q;
        loops_l_d = loops_l_q;
        wrap_d    = 1'b0;
        done_d    = 1'b0;

        if (bus.start) begin
            // Start wins over stop/tick in any state, so a restart is clean.
            loops_l_d = bus.loops;
            len_l_d   = bus.length;
            step_d    = '0;
            loop_d    = '0;
            state_d   = RUN;
        end else if (state_q == RUN) begin
            if (bus.stop) begin
                state_d = IDLE;
                step_d  = '0;
                loop_d  = '0;
            end else if (bus.step_tick && !pause) begin
                if (step_q == last_step) begin
                    step_d = '0;
                    wrap_d = 1'b1;
                    if ((loops_l_q != '0) && (loop_q == last_loop)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        loop_d  = '0;
                    end else begin
                        // Forever mode relies on natural wrap of the index.
                        loop_d = loop_q + 1'b1;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
        end

        play_d = (state_d == RUN) && !pause;
    end

    assign bus.play      = play_q;
    assign bus.step_idx  = step_q;
    assign bus.loop_idx  = loop_q;
    assign bus.loop_wrap = wrap_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_loop_step_counter.sv
module tb_loop_step_counter;
    localparam int STEP_W = 4;
    localparam int LOOP_W = 8;

    typedef struct {
        logic             play;
        logic [STEP_W-1:0] step;
        logic [LOOP_W-1:0] loop;
        logic             wrap;
        logic             done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    loop_step_counter_if #(.STEP_W(STEP_W), .LOOP_W(LOOP_W)) bus ();

    loop_step_counter #(.STEP_W(STEP_W), .LOOP_W(LOOP_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];

    // Behavioural reference: the run position is a flat tick count, and the
    // step/loop indices are derived from it arithmetically.
    bit m_run = 0;
    int m_pos = 0;
    int m_len = 16;
    int m_loops = 0;

    // Scoreboard monitor: one expected entry per clock edge.
    always @(posedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            #1;
            e = sb_q.pop_front();
            checks += 5;
            if (bus.play !== e.play) begin
                errors++; $display("FAIL play t=%0t got=%b want=%b", $time, bus.play, e.play);
            end
            if (bus.step_idx !== e.step) begin
                errors++; $display("FAIL step_idx t=%0t got=%0d want=%0d", $time, bus.step_idx, e.step);
            end
            if (bus.loop_idx !== e.loop) begin
                errors++; $display("FAIL loop_idx t=%0t got=%0d want=%0d", $time, bus.loop_idx, e.loop);
            end
            if (bus.loop_wrap !== e.wrap) begin
                errors++; $display("FAIL loop_wrap t=%0t got=%b want=%b", $time, bus.loop_wrap, e.wrap);
            end
            if (bus.done !== e.done) begin
                errors++; $display("FAIL done t=%0t got=%b want=%b", $time, bus.done, e.done);
            end
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    task automatic drive(input logic rs, input logic st, input logic sp, input logic tk,
                         input logic [LOOP_W-1:0] lp, input logic [STEP_W-1:0] ln,
                         input logic ps);
        exp_t e;
        logic eff_ps;
        rst           = rs;
        bus.start     = st;
        bus.stop      = sp;
        bus.step_tick = tk;
        bus.loops     = lp;
        bus.length    = ln;
`ifdef LOOP_STEP_COUNTER_PAUSE_EN
        bus.pause     = ps;
        eff_ps        = ps;
`else
        eff_ps        = 1'b0;
`endif
        e.wrap = 1'b0;
        e.done = 1'b0;
        if (rs) begin
            m_run = 0; m_pos = 0; m_len = 16; m_loops = 0;
        end else if (st) begin
            m_loops = int'(lp);
            m_len   = (ln == 0) ? (1 << STEP_W) : int'(ln);
            m_pos   = 0;
            m_run   = 1;
        end else if (m_run && sp) begin
            m_run = 0; m_pos = 0;
        end else if (m_run && tk && !eff_ps) begin
            m_pos++;
            if (m_pos % m_len == 0) e.wrap = 1'b1;
            if (m_loops != 0 && m_pos == m_loops * m_len) begin
                e.done = 1'b1; m_run = 0; m_pos = 0;
            end
        end
        e.play = m_run && !eff_ps;
        e.step = STEP_W'(m_pos % m_len);
        e.loop = LOOP_W'((m_pos / m_len) % (1 << LOOP_W));
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n, input logic [LOOP_W-1:0] lp, input logic [STEP_W-1:0] ln);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 1, lp, ln, 0);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 8'd0, 4'd0, 0);
        drive(1, 0, 0, 1, 8'd0, 4'd0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 8'd3, 4'd5, 0);
        checks++;
        if (bus.step_idx !== 4'd0 || bus.play !== 1'b0) begin
            errors++; $display("FAIL reset_idle got step=%0d play=%b want step=0 play=0", bus.step_idx, bus.play);
        end
    endtask

    task automatic test_finite();
        int d0;
        d0 = done_cnt;
        drive(0, 1, 0, 0, 8'd2, 4'd0, 0);
        checks++;
        if (bus.play !== 1'b1) begin
            errors++; $display("FAIL finite_play got=%b want=1", bus.play);
        end
        // Config inputs change mid-run; they must be ignored.
        ticks(16, 8'd7, 4'd3);
        checks++;
        if (bus.loop_wrap !== 1'b1 || bus.loop_idx !== 8'd1) begin
            errors++; $display("FAIL finite_wrap16 got wrap=%b loop=%0d want wrap=1 loop=1", bus.loop_wrap, bus.loop_idx);
        end
        ticks(16, 8'd7, 4'd3);
        checks++;
        if (bus.done !== 1'b1 || bus.loop_wrap !== 1'b1 || bus.play !== 1'b0 || bus.step_idx !== 4'd0) begin
            errors++; $display("FAIL finite_end got done=%b wrap=%b play=%b step=%0d want 1 1 0 0",
                               bus.done, bus.loop_wrap, bus.play, bus.step_idx);
        end
        ticks(1, 8'd7, 4'd3);
        checks++;
        if (bus.play !== 1'b0 || bus.done !== 1'b0 || (done_cnt - d0) !== 1) begin
            errors++; $display("FAIL finite_after got play=%b dones=%0d want play=0 dones=1", bus.play, done_cnt - d0);
        end
    endtask

    task automatic test_forever();
        int d0;
        d0 = done_cnt;
        drive(0, 1, 0, 0, 8'd0, 4'd3, 0);
        ticks(10, 8'd0, 4'd3);
        checks++;
        if (bus.step_idx !== 4'd1 || bus.loop_idx !== 8'd3 || bus.play !== 1'b1 || done_cnt != d0) begin
            errors++; $display("FAIL forever3 got step=%0d loop=%0d play=%b dones=%0d want 1 3 1 0",
                               bus.step_idx, bus.loop_idx, bus.play, done_cnt - d0);
        end
        // len=1: every tick wraps; loop index rolls over 255 -> 0.
        drive(0, 1, 0, 0, 8'd0, 4'd1, 0);
        ticks(257, 8'd0, 4'd1);
        checks++;
        if (bus.loop_idx !== 8'd1 || bus.loop_wrap !== 1'b1 || done_cnt != d0) begin
            errors++; $display("FAIL forever_rollover got loop=%0d wrap=%b want loop=1 wrap=1", bus.loop_idx, bus.loop_wrap);
        end
        drive(0, 0, 1, 0, 8'd0, 4'd1, 0);
    endtask

    task automatic test_restart();
        int d0;
        drive(0, 1, 0, 0, 8'd3, 4'd4, 0);
        ticks(5, 8'd3, 4'd4);
        d0 = done_cnt;
        drive(0, 1, 0, 0, 8'd1, 4'd2, 0);
        checks++;
        if (bus.step_idx !== 4'd0 || bus.loop_idx !== 8'd0 || bus.play !== 1'b1 || done_cnt != d0) begin
            errors++; $display("FAIL restart got step=%0d loop=%0d play=%b want 0 0 1", bus.step_idx, bus.loop_idx, bus.play);
        end
        ticks(1, 8'd1, 4'd2);
        ticks(1, 8'd1, 4'd2);
        checks++;
        if (bus.done !== 1'b1 || (done_cnt - d0) !== 1) begin
            errors++; $display("FAIL restart_done got done=%b dones=%0d want 1 1", bus.done, done_cnt - d0);
        end
    endtask

    task automatic test_stop();
        int d0;
        d0 = done_cnt;
        drive(0, 1, 0, 0, 8'd5, 4'd4, 0);
        ticks(6, 8'd5, 4'd4);
        drive(0, 0, 1, 0, 8'd5, 4'd4, 0);
        checks++;
        if (bus.play !== 1'b0 || bus.step_idx !== 4'd0 || bus.loop_idx !== 8'd0 || done_cnt != d0) begin
            errors++; $display("FAIL stop got play=%b step=%0d loop=%0d want 0 0 0", bus.play, bus.step_idx, bus.loop_idx);
        end
        drive(0, 0, 1, 1, 8'd5, 4'd4, 0);
        drive(0, 1, 0, 0, 8'd5, 4'd4, 0);
        ticks(6, 8'd5, 4'd4);
        drive(0, 1, 1, 1, 8'd5, 4'd4, 0);
        checks++;
        if (bus.play !== 1'b1 || bus.step_idx !== 4'd0) begin
            errors++; $display("FAIL start_stop got play=%b step=%0d want play=1 step=0", bus.play, bus.step_idx);
        end
        ticks(3, 8'd5, 4'd4);
        drive(1, 0, 0, 1, 8'd5, 4'd4, 0);
        checks++;
        if (bus.play !== 1'b0 || bus.step_idx !== 4'd0 || done_cnt != d0) begin
            errors++; $display("FAIL reset_midrun got play=%b step=%0d want 0 0", bus.play, bus.step_idx);
        end
    endtask

`ifdef LOOP_STEP_COUNTER_PAUSE_EN
    task automatic test_pause();
        drive(0, 1, 0, 0, 8'd1, 4'd4, 0);
        ticks(2, 8'd1, 4'd4);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 8'd1, 4'd4, 1);
        checks++;
        if (bus.step_idx !== 4'd2 || bus.play !== 1'b0) begin
            errors++; $display("FAIL pause got step=%0d play=%b want 2 0", bus.step_idx, bus.play);
        end
        drive(0, 0, 0, 0, 8'd1, 4'd4, 0);
        ticks(2, 8'd1, 4'd4);
        checks++;
        if (bus.done !== 1'b1) begin
            errors++; $display("FAIL pause_done got=%b want=1", bus.done);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.stop = 0; bus.step_tick = 0; bus.loops = '0; bus.length = '0;
`ifdef LOOP_STEP_COUNTER_PAUSE_EN
        bus.pause = 0;
`endif
        #2;
        test_reset();
        test_finite();
        test_forever();
        test_restart();
        test_stop();
`ifdef LOOP_STEP_COUNTER_PAUSE_EN
        test_pause();
`endif
        drive(0, 0, 0, 0, 8'd0, 4'd0, 0);
        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
